// File: rtl/alu_iterative.sv
// alu_iterative -- multi-cycle ALU with valid/ready handshakes.
//
// Single-step ops (add, sub, and, or, slt, xor, and shifts by 0) finish one
// cycle after acceptance. sll/srl with a nonzero amount iterate, moving at
// most SHIFT_STEP bit positions per cycle, so only a SHIFT_STEP-way shift mux
// is needed instead of a full barrel shifter.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (accepted only in IDLE)
//   alu_control           000 add, 001 sub, 010 and, 011 or,
//                         100 sll, 101 slt, 110 srl, 111 xor
//   src_a, src_b          operands; shift amount is src_b[log2(WIDTH)-1:0]
//   out_valid / out_ready result handshake (held in DONE until accepted)
//   result, zero          registered result and (result == 0)
//   busy                  high whenever the FSM is not IDLE
module alu_iterative #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] STEP = SW'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;        // 1 = logical right, 0 = left
  logic [WIDTH-1:0] work_q, work_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [SW-1:0]    amt;
  logic             is_shift;
  logic [WIDTH-1:0] alu_res;
  logic [SW-1:0]    k;
  logic [WIDTH-1:0] shifted;

  assign amt      = src_b[SW-1:0];
  assign is_shift = (alu_control == 3'b100) || (alu_control == 3'b110);

  // Single-cycle datapath. Shift codes only reach here with amount 0,
  // where the result is simply operand A.
  always_comb begin
    alu_res = '0;
    case (alu_control)
      3'b000:  alu_res = src_a + src_b;
      3'b001:  alu_res = src_a - src_b;
      3'b010:  alu_res = src_a & src_b;
      3'b011:  alu_res = src_a | src_b;
      3'b101:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      3'b111:  alu_res = src_a ^ src_b;
      default: alu_res = src_a;
    endcase
  end

  // One shift step of k = min(SHIFT_STEP, remaining) positions, built as a
  // mux over the constant shifts 1..SHIFT_STEP.
  always_comb begin
    k       = (rem_q < STEP) ? rem_q : STEP;
    shifted = work_q;
    for (int i = 1; i <= SHIFT_STEP; i++) begin
      if (k == SW'(i)) shifted = dir_q ? (work_q >> i) : (work_q << i);
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    work_d   = work_q;
    rem_d    = rem_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_shift && (amt != '0)) begin
            work_d  = src_a;
            rem_d   = amt;
            dir_d   = alu_control[1];
            state_d = SHIFT;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - k;
        if (rem_q == k) begin
          result_d = shifted;
          zero_d   = (shifted == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE here means a new request can only be taken on
        // the following edge.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      work_q   <= '0;
      rem_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_iterative.sv
module tb_alu_iterative;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  ctrl;
  logic [31:0] a, b;
  logic        in_valid, in_valid4, out_ready, out_ready4;
  logic        in_ready, out_valid, zero, busy;
  logic        in_ready4, out_valid4, zero4, busy4;
  logic [31:0] result, result4;

  alu_iterative #(.WIDTH(32), .SHIFT_STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(ctrl), .src_a(a), .src_b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .busy(busy));

  alu_iterative #(.WIDTH(32), .SHIFT_STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .alu_control(ctrl), .src_a(a), .src_b(b), .out_valid(out_valid4),
    .out_ready(out_ready4), .result(result4), .zero(zero4), .busy(busy4));

  // sel4 picks which instance the shared tasks talk to
  logic        sel4 = 1'b0;
  logic        ov_m, ir_m, zero_m, busy_m;
  logic [31:0] res_m;
  assign ov_m   = sel4 ? out_valid4 : out_valid;
  assign ir_m   = sel4 ? in_ready4  : in_ready;
  assign zero_m = sel4 ? zero4      : zero;
  assign busy_m = sel4 ? busy4      : busy;
  assign res_m  = sel4 ? result4    : result;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x << y[4:0];
      3'd5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd6: return x >> y[4:0];
      default: return x ^ y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] c, input logic [31:0] y, input int step);
    if (c == 3'd4 || c == 3'd6) return (int'(y[4:0]) + step - 1) / step;
    return 0;
  endfunction

  // Drive one request on the selected instance and push its expectation.
  // Operands are scrambled after acceptance to prove they were captured.
  task automatic issue(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e, input int lat);
    @(negedge clk);
    ctrl = c; a = x; b = y;
    if (sel4) in_valid4 = 1'b1; else in_valid = 1'b1;
    sb.push_back('{res: e, z: (e == 32'd0), lat: lat});
    @(negedge clk);
    in_valid = 1'b0; in_valid4 = 1'b0;
    ctrl = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  // Cycles from the first negedge after acceptance until out_valid (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (ov_m !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    if (sel4) out_ready4 = 1'b1; else out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (result !== 32'd0 || zero !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: res=%h z=%b ov=%b busy=%b ir=%b, required 0 0 0 0 1",
               result, zero, out_valid, busy, in_ready);
    end
    checks++;
    if (result4 !== 32'd0 || out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL reset_state4: res=%h ov=%b ir=%b, required 0 0 1", result4, out_valid4, in_ready4);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic [2:0]  tc [10] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd5, 3'd5, 3'd7, 3'd2, 3'd3, 3'd5};
    logic [31:0] ta [10] = '{32'h5, 32'h7, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,
                             32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'h8000_0000};
    logic [31:0] tb [10] = '{32'h3, 32'h7, 32'h1, 32'h1, 32'h1, 32'hFFFF_FFFF,
                             32'hFFFF_0000, 32'hFFFF_0000, 32'h0F0F_0000, 32'h7FFF_FFFF};
    logic [31:0] te [10] = '{32'h8, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0,
                             32'h0F0F_F0F0, 32'hF0F0_0000, 32'hFFFF_F0F0, 32'h1};
    int   lat;
    exp_t e;
    sel4 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i < 10) issue(tc[i], ta[i], tb[i], te[i], 0);
      else begin
        logic [2:0]  c = 3'($urandom);
        logic [31:0] x = $urandom;
        logic [31:0] y = $urandom;
        if (i % 4 == 0) y = x;   // exercise zero results and equal compares
        issue(c, x, y, model(c, x, y), model_lat(c, y, 1));
      end
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if (res_m !== e.res || zero_m !== e.z || lat != e.lat) begin
        errors++;
        $display("FAIL arith[%0d]: res=%h z=%b lat=%0d, required res=%h z=%b lat=%0d",
                 i, res_m, zero_m, lat, e.res, e.z, e.lat);
      end
      consume();
    end
  endtask

  task automatic test_shift();
    logic [2:0]  tc [7] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4};
    logic [31:0] ta [7] = '{32'h1, 32'h8000_0000, 32'hABCD, 32'h1234, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] tb [7] = '{32'h25, 32'd31, 32'h0, 32'h20, 32'd31, 32'd1, 32'd1};
    logic [31:0] te [7] = '{32'h20, 32'h1, 32'hABCD, 32'h1234, 32'h8000_0000, 32'h4000_0000, 32'h0};
    int          tl [7] = '{5, 31, 0, 0, 31, 1, 1};
    int   lat;
    exp_t e;
    sel4 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      issue(tc[i], ta[i], tb[i], te[i], tl[i]);
      if (tl[i] > 0) begin
        checks++;
        if (busy_m !== 1'b1 || ir_m !== 1'b0 || ov_m !== 1'b0) begin
          errors++;
          $display("FAIL shift_busy[%0d]: busy=%b ir=%b ov=%b, required 1 0 0", i, busy_m, ir_m, ov_m);
        end
      end
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if (res_m !== e.res || zero_m !== e.z || lat != e.lat) begin
        errors++;
        $display("FAIL shift[%0d]: res=%h z=%b lat=%0d, required res=%h z=%b lat=%0d",
                 i, res_m, zero_m, lat, e.res, e.z, e.lat);
      end
      consume();
    end
  endtask

  task automatic test_step4();
    logic [2:0]  tc [5] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd4};
    logic [31:0] ta [5] = '{32'h3, 32'hF000_0000, 32'h1, 32'h8000_0000, 32'h5};
    logic [31:0] tb [5] = '{32'd6, 32'd7, 32'd3, 32'd31, 32'd4};
    logic [31:0] te [5] = '{32'hC0, 32'h01E0_0000, 32'h8, 32'h1, 32'h50};
    int          tl [5] = '{2, 2, 1, 8, 1};
    int   lat;
    exp_t e;
    sel4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(tc[i], ta[i], tb[i], te[i], tl[i]);
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if (res_m !== e.res || zero_m !== e.z || lat != e.lat) begin
        errors++;
        $display("FAIL step4[%0d]: res=%h z=%b lat=%0d, required res=%h z=%b lat=%0d",
                 i, res_m, zero_m, lat, e.res, e.z, e.lat);
      end
      consume();
    end
    sel4 = 1'b0;
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    sel4 = 1'b0;
    issue(3'd0, 32'h10, 32'h20, 32'h30, 0);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (res_m !== e.res || lat != 0) begin
      errors++;
      $display("FAIL bp_first: res=%h lat=%0d, required res=%h lat=0", res_m, lat, e.res);
    end
    // Stalled consumer with a competing request that must be ignored.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; ctrl = 3'd1; a = 32'h1; b = 32'h1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h30 || zero !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: ov=%b res=%h z=%b ir=%b, required 1 00000030 0 0",
                 i, out_valid, result, zero, in_ready);
      end
    end
    // Release with in_valid still high: that edge must not accept.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h30) begin
      errors++;
      $display("FAIL bp_release: ov=%b ir=%b res=%h, required 0 1 00000030", out_valid, in_ready, result);
    end
    issue(3'd1, 32'h9, 32'h4, 32'h5, 0);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (res_m !== e.res || zero_m !== e.z || lat != 0) begin
      errors++;
      $display("FAIL bp_next: res=%h z=%b lat=%0d, required res=%h z=%b lat=0", res_m, zero_m, lat, e.res, e.z);
    end
    consume();
  endtask

  task automatic test_reset_mid_shift();
    int   lat;
    int   seen;
    exp_t e;
    sel4 = 1'b0;
    @(negedge clk);
    ctrl = 3'd6; a = 32'hFFFF_0000; b = 32'd20; in_valid = 1'b1;
    @(negedge clk);                // SHIFT cycle 1
    in_valid = 1'b0;
    repeat (2) @(negedge clk);     // SHIFT cycle 3
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid: busy=%b ov=%b res=%h z=%b ir=%b, required 0 0 0 0 1",
               busy, out_valid, result, zero, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_no_out: out_valid pulses=%0d, required 0", seen);
    end
    issue(3'd0, 32'h2, 32'h3, 32'h5, 0);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (res_m !== e.res || zero_m !== e.z || lat != 0) begin
      errors++;
      $display("FAIL rst_after_add: res=%h z=%b lat=%0d, required res=%h z=%b lat=0", res_m, zero_m, lat, e.res, e.z);
    end
    consume();
  endtask

  // Request and out_ready held high: one accept every 2 cycles.
  task automatic test_back_to_back();
    exp_t e;
    int   n_res = 0;
    sel4 = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid === 1'b1) begin
        n_res++;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b2b_extra: unexpected result %h", result);
        end else begin
          e = sb.pop_front();
          checks++;
          if (result !== e.res || zero !== e.z) begin
            errors++;
            $display("FAIL b2b[%0d]: res=%h z=%b, required res=%h z=%b", i, result, zero, e.res, e.z);
          end
        end
      end
      if (in_ready === 1'b1) begin
        ctrl = 3'($urandom); a = $urandom; b = $urandom;
        if (ctrl == 3'd4 || ctrl == 3'd6) b[4:0] = 5'd0;
        sb.push_back('{res: model(ctrl, a, b), z: (model(ctrl, a, b) == 32'd0), lat: 0});
      end else begin
        ctrl = 3'($urandom); a = $urandom; b = $urandom;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (n_res != 10 || sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: results=%0d pending=%0d ov=%b, required 10 0 0", n_res, sb.size(), out_valid);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0; out_ready4 = 1'b0;
    ctrl = 3'd0; a = 32'd0; b = 32'd0;
    test_reset();
    test_arith();
    test_shift();
    test_step4();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Execution-side consumer of the 3-bit ALU control code produced by the ALU decoder.
- Multi-cycle ALU with valid/ready handshakes on input and output. Intended for the multi-cycle/pipelined core variant.
- Single-step ops (add, sub, and, or, slt, xor) complete in one cycle. Shifts (sll, srl) run iteratively, SHIFT_STEP bit positions per cycle, to cut barrel-shifter area.
- Outputs the result and a zero flag; the zero flag is used for beq, and the slt result for blt.

Parameters:
- WIDTH, 32, datapath width in bits. Must be a power of 2, at least 8.
- SHIFT_STEP, 1, bit positions shifted per SHIFT cycle. Must be a power of 2, from 1 to WIDTH/2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request.
- alu_control  input  3  operation code: 000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt, 110 srl, 111 xor.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B; for shifts, the shift amount is src_b[log2(WIDTH)-1:0].
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE. result=0, zero=0, out_valid=0, busy=0, in_ready=1 after release. Internal working register and counter are cleared.
- Reset mid-operation: the in-flight operation is discarded with no output.
- States:
  - IDLE: in_ready=1. Accept edge = rising edge with in_valid && in_ready. Operands and code are captured only on the accept edge; later input changes are ignored.
  - SHIFT: iterative shifting; in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- IDLE transitions on accept:
  - Non-shift code, or shift with amount 0: compute the result combinationally from the captured inputs, register it, go to DONE. out_valid is high in the cycle after the accept edge.
  - Shift with amount > 0: load work=src_a and remaining=amount, go to SHIFT.
- SHIFT, per edge:
  - Shift work by k = min(SHIFT_STEP, remaining): left for sll, logical right for srl (zero fill).
  - remaining -= k.
  - When remaining reaches 0 on this edge, result=shifted value and go to DONE.
  - out_valid rises ceil(amount/SHIFT_STEP) cycles later than it would for a non-shift op.
- DONE: result and zero are held stable while out_valid && !out_ready. On an edge with out_ready=1, go to IDLE and deassert out_valid. No new request is accepted on that same edge; minimum issue interval is 2 cycles.
- Arithmetic:
  - add/sub: modulo 2^WIDTH; carry and overflow are discarded.
  - slt: signed two's-complement compare; result = {(WIDTH-1){0}, a<b}.
  - and/or/xor: bitwise.
  - Shift amount: only the low log2(WIDTH) bits of src_b are used; upper bits are ignored.
  - zero: registered together with result, equal to (result == 0).
- Output stability: result and zero change only on the edge entering DONE or on reset. In IDLE and SHIFT they hold the last completed value.
- Every 3-bit code is defined; none produces X.

Test Plan:
- Reset, then add: rst_n low for 2 cycles → all outputs 0, in_ready=1. Then add with a=0x0000_0005, b=0x0000_0003 → out_valid the next cycle, result=0x0000_0008, zero=0.
- Sub and wrap: sub a=0x0000_0007, b=0x0000_0007 → result=0, zero=1. Sub a=0, b=1 → result=0xFFFF_FFFF, zero=0. Add 0xFFFF_FFFF+1 → result=0, zero=1.
- Signed compare: slt a=0xFFFF_FFFF (-1), b=0x0000_0001 → result=1. slt a=1, b=0xFFFF_FFFF → result=0. xor 0xF0F0_F0F0 ^ 0xFFFF_0000 → 0x0F0F_F0F0.
- Iterative shifts, SHIFT_STEP=1:
  - sll a=0x0000_0001, b=0x25 (amount 5) → busy for 5 SHIFT cycles, then out_valid, result=0x0000_0020.
  - srl a=0x8000_0000, amount 31 → result=0x0000_0001, 31 SHIFT cycles.
  - Amount 0 → result=a after 1 cycle.
  - With SHIFT_STEP=4, amount 6 → 2 SHIFT cycles, result correct.
- Backpressure: hold out_ready=0 for 10 cycles after a result → out_valid stays 1, result stable, in_ready=0, and a new in_valid is ignored. Raise out_ready → IDLE next cycle; the following request is accepted.
- Reset mid-shift: assert rst_n low during the 3rd SHIFT cycle of an srl with amount 20 → immediately IDLE with outputs 0. No out_valid pulse after release. The next add runs correctly.
